titan_clint: RTL

TITAN_CLINT -- requirements
Module: titan_clint

---
 rtl/titan_defines.sv | 44 ++++
 rtl/titan_clint_timer.sv | 44 ++++
 rtl/titan_clint.sv | 130 +++++++++++++
 3 files changed

// File: rtl/titan_defines.sv
// Shared titan core constants: machine-mode CSR numbers plus the CLINT register map,
// register selector and bus FSM encoding.
package titan_defines;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam int unsigned MIP_MSIP_BIT = 3;
    localparam int unsigned MIP_MTIP_BIT = 7;

    // CLINT register offsets within the 64 KiB window
    localparam logic [15:0] CLINT_OFF_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_OFF_MTCMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_OFF_MTCMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] CLINT_OFF_MTIME_HI = 16'hBFFC;

    localparam logic [0:0] CLINT_ST_IDLE = 1'b0;
    localparam logic [0:0] CLINT_ST_RESP = 1'b1;

    typedef enum logic [2:0] {
        CLINT_REG_NONE,
        CLINT_REG_MSIP,
        CLINT_REG_MTCMP_LO,
        CLINT_REG_MTCMP_HI,
        CLINT_REG_MTIME_LO,
        CLINT_REG_MTIME_HI
    } clint_reg_e;

    function automatic logic [31:0] clint_merge(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/titan_clint_timer.sv
// 64-bit mtime counter advanced by a 16-bit prescaler; either half can be loaded,
// and a load cycle takes priority over the tick so software sees exactly what it wrote.
module titan_clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_lo_i,
    input  logic        ld_hi_i,
    input  logic [31:0] ld_data_i,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d = mtime_q;
        if (ld_lo_i || ld_hi_i) begin
            if (ld_lo_i) mtime_d[31:0]  = ld_data_i;
            if (ld_hi_i) mtime_d[63:32] = ld_data_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/titan_clint.sv
// titan_clint: core-local interruptor (msip, mtimecmp, mtime) behind a Wishbone slave.
// Every accepted request terminates one cycle later with exactly one of ack or err.
module titan_clint
    import titan_defines::*;
#(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    logic [0:0]  state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        mtip_q, mtip_d;
    logic [63:0] mtime;
    clint_reg_e  reg_sel;
    logic        req, accept, wr;
    logic        ld_lo, ld_hi;
    logic [31:0] ld_data;
    logic [15:0] unused_addr_hi;

    // Only the low 16 address bits select a register; the window base is decoded upstream.
    assign unused_addr_hi = wbs_addr_i[31:16];

    always_comb begin
        reg_sel = CLINT_REG_NONE;
        if (wbs_addr_i[1:0] == 2'b00) begin
            case (wbs_addr_i[15:0])
                CLINT_OFF_MSIP:     reg_sel = CLINT_REG_MSIP;
                CLINT_OFF_MTCMP_LO: reg_sel = CLINT_REG_MTCMP_LO;
                CLINT_OFF_MTCMP_HI: reg_sel = CLINT_REG_MTCMP_HI;
                CLINT_OFF_MTIME_LO: reg_sel = CLINT_REG_MTIME_LO;
                CLINT_OFF_MTIME_HI: reg_sel = CLINT_REG_MTIME_HI;
                default:            reg_sel = CLINT_REG_NONE;
            endcase
        end
    end

    assign req    = wbs_cyc_i & wbs_stb_i;
    assign accept = req && (state_q == CLINT_ST_IDLE) && !rst_i;
    assign wr     = accept && wbs_we_i && (reg_sel != CLINT_REG_NONE);

    always_comb begin
        state_d = (state_q == CLINT_ST_IDLE && req) ? CLINT_ST_RESP : CLINT_ST_IDLE;
        ack_d   = accept && (reg_sel != CLINT_REG_NONE);
        err_d   = accept && (reg_sel == CLINT_REG_NONE);

        rdata_d = '0;
        if (accept && !wbs_we_i) begin
            case (reg_sel)
                CLINT_REG_MSIP:     rdata_d = {31'd0, msip_q};
                CLINT_REG_MTCMP_LO: rdata_d = mtimecmp_q[31:0];
                CLINT_REG_MTCMP_HI: rdata_d = mtimecmp_q[63:32];
                CLINT_REG_MTIME_LO: rdata_d = mtime[31:0];
                CLINT_REG_MTIME_HI: rdata_d = mtime[63:32];
                default:            rdata_d = '0;
            endcase
        end

        msip_d = msip_q;
        if (wr && reg_sel == CLINT_REG_MSIP && wbs_sel_i[0]) msip_d = wbs_dat_i[0];

        mtimecmp_d = mtimecmp_q;
        if (wr && reg_sel == CLINT_REG_MTCMP_LO)
            mtimecmp_d[31:0] = clint_merge(mtimecmp_q[31:0], wbs_dat_i, wbs_sel_i);
        if (wr && reg_sel == CLINT_REG_MTCMP_HI)
            mtimecmp_d[63:32] = clint_merge(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);

        // An all-lanes-off write must not load mtime, or it would swallow a tick.
        ld_lo   = wr && (reg_sel == CLINT_REG_MTIME_LO) && (|wbs_sel_i);
        ld_hi   = wr && (reg_sel == CLINT_REG_MTIME_HI) && (|wbs_sel_i);
        ld_data = clint_merge(ld_hi ? mtime[63:32] : mtime[31:0], wbs_dat_i, wbs_sel_i);

        mtip_d = (mtime >= mtimecmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLINT_ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            mtimecmp_q <= MTIMECMP_RST;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
        end
    end

    titan_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ld_lo_i   (ld_lo),
        .ld_hi_i   (ld_hi),
        .ld_data_i (ld_data),
        .mtime_o   (mtime)
    );

    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign wbs_dat_o   = ack_q ? rdata_q : '0;
    assign xint_mtip_o = mtip_q;
    assign xint_msip_o = msip_q;

endmodule
